// File: rtl/mux_pipe_nx1.sv
// rtl/mux_pipe_nx1.sv - pipelined N:1 word select with ready/valid and a one-entry skid buffer
//
// Purpose:
//   Selects word Sel out of N_IN words on In_Bus and forwards it, together with
//   Sel and an out-of-range flag, through a registered output stage. A one-entry
//   skid register absorbs the entry accepted in the cycle when the output stalls.
//   Because of that skid register, In_Ready is a pure flop (!skid_v) and has no
//   combinational path from Out_Ready.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous active-low reset
//   In_Bus     in   N_IN*WIDTH flattened words, word k = In_Bus[k*WIDTH +: WIDTH]
//   Sel        in   index of the word to forward, sampled with In_Bus
//   In_Valid   in   upstream offers In_Bus/Sel
//   In_Ready   out  block can accept this cycle
//   Out        out  selected word (0 for an out-of-range Sel)
//   Out_Sel    out  Sel value that produced Out
//   Sel_Err    out  Out came from Sel >= N_IN
//   Out_Valid  out  Out/Out_Sel/Sel_Err valid
//   Out_Ready  in   downstream accepts
//   Err_Count  out  saturating count of accepted out-of-range selects
//
// Build option:
//   MUX_PIPE_ERR_COUNT_EN  when defined, Err_Count counts accepted entries with
//                          Sel >= N_IN and saturates at 255; when undefined,
//                          Err_Count is tied to 0 and the counter is absent.

module mux_pipe_nx1 #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 8,
  parameter int SEL_W = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [N_IN*WIDTH-1:0] In_Bus,
  input  logic [SEL_W-1:0]      Sel,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic [WIDTH-1:0]      Out,
  output logic [SEL_W-1:0]      Out_Sel,
  output logic                  Sel_Err,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [7:0]            Err_Count
);

  // One bit wider than Sel so that N_IN = 2**SEL_W is representable.
  localparam logic [SEL_W:0] N_IN_W = (SEL_W + 1)'(N_IN);

  // Incoming entry, formed combinationally from the upstream offer.
  logic [WIDTH-1:0] in_word;
  logic             in_err;
  logic             accept;
  logic             out_free;

  // Output register.
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q,  out_sel_d;
  logic             out_err_q,  out_err_d;
  logic             out_valid_q, out_valid_d;

  // Skid register.
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q,  skid_sel_d;
  logic             skid_err_q,  skid_err_d;
  logic             skid_v_q,    skid_v_d;

  // ---------------------------------------------------------------------------
  // Word select. An out-of-range Sel matches no word, so the word stays 0
  // rather than aliasing onto a real input.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_word = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (Sel == SEL_W'(k)) begin
        in_word = In_Bus[k*WIDTH +: WIDTH];
      end
    end
    in_err = ({1'b0, Sel} >= N_IN_W);
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign In_Ready = !skid_v_q;
  assign accept   = In_Valid && !skid_v_q;
  assign out_free = !out_valid_q || Out_Ready;

  // ---------------------------------------------------------------------------
  // Next-state for the two storage registers. Data fields only load on a real
  // transfer, so nothing from an idle (possibly undriven) In_Bus reaches state.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;
    skid_v_d    = skid_v_q;

    if (skid_v_q) begin
      // Skid holds the older entry; it must go out before anything new.
      if (out_free) begin
        out_data_d  = skid_data_q;
        out_sel_d   = skid_sel_q;
        out_err_d   = skid_err_q;
        out_valid_d = 1'b1;
        skid_v_d    = 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_data_d  = in_word;
        out_sel_d   = Sel;
        out_err_d   = in_err;
        out_valid_d = 1'b1;
      end else begin
        // Output is stalled: park the entry and drop In_Ready next cycle.
        skid_data_d = in_word;
        skid_sel_d  = Sel;
        skid_err_d  = in_err;
        skid_v_d    = 1'b1;
      end
    end else if (out_free) begin
      // Nothing new; the current output (if any) drains this cycle.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
      skid_v_q    <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_err_q  <= skid_err_d;
      skid_v_q    <= skid_v_d;
    end
  end

  assign Out       = out_data_q;
  assign Out_Sel   = out_sel_q;
  assign Sel_Err   = out_err_q;
  assign Out_Valid = out_valid_q;

  // ---------------------------------------------------------------------------
  // Out-of-range select counter. Counted at accept time, so an entry is counted
  // exactly once whether it goes straight to the output or via the skid.
  // ---------------------------------------------------------------------------
`ifdef MUX_PIPE_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && in_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Err_Count = err_cnt_q;
`else
  assign Err_Count = 8'h00;
`endif

endmodule

// File: tb/tb_mux_pipe_nx1.sv
// tb/tb_mux_pipe_nx1.sv - scoreboard bench for mux_pipe_nx1 (N_IN=8 and N_IN=6 instances)

module tb_mux_pipe_nx1;

`ifdef MUX_PIPE_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [2:0]  sel;
    logic        err;
  } entry_t;

  logic clk;
  logic rst_n;

  // Main instance: WIDTH=32, N_IN=8, SEL_W=3.
  logic [8*32-1:0] in_bus;
  logic [2:0]      sel;
  logic            in_valid, in_ready;
  logic [31:0]     out;
  logic [2:0]      out_sel;
  logic            sel_err, out_valid, out_ready;
  logic [7:0]      err_count;

  // Out-of-range instance: WIDTH=32, N_IN=6, SEL_W=3.
  logic [6*32-1:0] in_bus6;
  logic [2:0]      sel6;
  logic            in_valid6, in_ready6;
  logic [31:0]     out6;
  logic [2:0]      out_sel6;
  logic            sel_err6, out_valid6, out_ready6;
  logic [7:0]      err_count6;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_cnt6 = 0;
  entry_t q_main[$];
  entry_t q_six[$];

  mux_pipe_nx1 #(.WIDTH(32), .N_IN(8), .SEL_W(3)) dut (
    .Clk(clk), .Rst_n(rst_n), .In_Bus(in_bus), .Sel(sel), .In_Valid(in_valid),
    .In_Ready(in_ready), .Out(out), .Out_Sel(out_sel), .Sel_Err(sel_err),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Err_Count(err_count)
  );

  mux_pipe_nx1 #(.WIDTH(32), .N_IN(6), .SEL_W(3)) dut6 (
    .Clk(clk), .Rst_n(rst_n), .In_Bus(in_bus6), .Sel(sel6), .In_Valid(in_valid6),
    .In_Ready(in_ready6), .Out(out6), .Out_Sel(out_sel6), .Sel_Err(sel_err6),
    .Out_Valid(out_valid6), .Out_Ready(out_ready6), .Err_Count(err_count6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t model(input logic [2:0] s, input int n);
    entry_t e;
    e.sel  = s;
    e.err  = (int'(s) >= n);
    e.data = e.err ? 32'h0 : (32'h1000_0000 + 32'(s));
    return e;
  endfunction

  // Input monitors: record what the DUT accepted, with the bench's own expectation.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) q_main.push_back(model(sel, 8));
    if (rst_n && in_valid6 && in_ready6) begin
      q_six.push_back(model(sel6, 6));
      if (CNT_EN && int'(sel6) >= 6 && exp_cnt6 < 255) exp_cnt6++;
    end
  end

  // Output monitors: pop and compare whenever an entry is emitted.
  always @(negedge clk) begin
    entry_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q_main.size() == 0) begin
        check("main_unexpected_output", 64'(out), 64'hDEAD);
      end else begin
        e = q_main.pop_front();
        check("main_out", 64'(out), 64'(e.data));
        check("main_out_sel", 64'(out_sel), 64'(e.sel));
        check("main_sel_err", 64'(sel_err), 64'(e.err));
      end
    end
    if (rst_n && out_valid6 && out_ready6) begin
      if (q_six.size() == 0) begin
        check("six_unexpected_output", 64'(out6), 64'hDEAD);
      end else begin
        e = q_six.pop_front();
        check("six_out", 64'(out6), 64'(e.data));
        check("six_out_sel", 64'(out_sel6), 64'(e.sel));
        check("six_sel_err", 64'(sel_err6), 64'(e.err));
      end
    end
  end

  // Offer one entry on the main instance; called at posedge+1, returns at posedge+1
  // after the accepting edge. waited = cycles spent with In_Ready low.
  task automatic send(input logic [2:0] s, output int waited);
    waited = 0;
    sel = s;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("send_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send6(input logic [2:0] s);
    int w = 0;
    sel6 = s;
    in_valid6 = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready6) break;
      w++;
      if (w > 50) begin
        check("send6_timeout", 64'(w), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid6 = 1'b0;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((q_main.size() != 0 || q_six.size() != 0 || out_valid || out_valid6) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, 64'(q_main.size() + q_six.size()), 64'd0);
  endtask

  initial begin
    int w;
    for (int k = 0; k < 8; k++) in_bus[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    for (int k = 0; k < 6; k++) in_bus6[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    sel = 3'd0; in_valid = 1'b0; out_ready = 1'b1;
    sel6 = 3'd0; in_valid6 = 1'b0; out_ready6 = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out", 64'(out), 64'd0);
    check("reset_err_count", 64'(err_count6), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single transfer: visible the cycle after accept, for one cycle only.
    send(3'd5, w);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_out", 64'(out), 64'h1000_0005);
    check("single_out_sel", 64'(out_sel), 64'd5);
    check("single_sel_err", 64'(sel_err), 64'd0);
    @(posedge clk); #1;
    check("single_one_cycle", 64'(out_valid), 64'd0);

    // Back-to-back streaming with Out_Ready high: In_Ready never drops.
    for (int i = 0; i < 8; i++) begin
      send(3'(i), w);
      check("stream_no_stall", 64'(w), 64'd0);
    end
    drain("stream_drained");

    // Backpressure: 2 lands in output, 3 in skid, 4 must wait.
    out_ready = 1'b0;
    send(3'd2, w);
    send(3'd3, w);
    check("skid_in_ready_low", 64'(in_ready), 64'd0);
    sel = 3'd4;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("skid_blocks_third", 64'(in_ready), 64'd0);
      check("skid_out_hold", 64'(out), 64'h1000_0002);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        check("skid_release_timeout", 64'(w), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("skid_drained");

    // Out-of-range select on the N_IN=6 instance.
    send6(3'd7);
    check("oor_out", 64'(out6), 64'd0);
    check("oor_sel_err", 64'(sel_err6), 64'd1);
    check("oor_out_sel", 64'(out_sel6), 64'd7);
    check("oor_count_1", 64'(err_count6), CNT_EN ? 64'd1 : 64'd0);
    send6(3'd5);
    check("inrange_out6", 64'(out6), 64'h1000_0005);
    for (int i = 0; i < 299; i++) send6((i % 2 == 0) ? 3'd6 : 3'd7);
    drain("oor_drained");
    check("oor_count_sat", 64'(err_count6), CNT_EN ? 64'd255 : 64'd0);
    check("oor_count_model", 64'(err_count6), 64'(exp_cnt6));

    // Reset mid-operation with both registers of the main instance full.
    out_ready = 1'b0;
    send(3'd1, w);
    send(3'd6, w);
    check("mid_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out", 64'(out), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_sel_err", 64'(sel_err), 64'd0);
    check("mid_rst_err_count", 64'(err_count6), 64'd0);
    q_main.delete();
    q_six.delete();
    exp_cnt6 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(3'd3, w);
    check("post_rst_latency", 64'(out_valid), 64'd1);
    check("post_rst_out", 64'(out), 64'h1000_0003);
    drain("final_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux_pipe_nx1.md
Name: mux_pipe_nx1

Overview:
- Parametrised, pipelined N:1 word multiplexer. Next generation of the team's combinational 8:1 x 32 select.
- Adds ready/valid flow control on both sides, a registered output, and a one-entry skid buffer, so the select can sit between pipeline stages of the ALU result path without combinational paths from Out_Ready to In_Ready.
- Flags out-of-range selects instead of silently aliasing them.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- N_IN, 8, number of input words (2..64).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= N_IN.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset, asynchronous assert, active-low.
- In_Bus  input  N_IN*WIDTH  flattened inputs; word k = In_Bus[k*WIDTH +: WIDTH].
- Sel  input  SEL_W  index of the word to forward; sampled with In_Bus.
- In_Valid  input  1  upstream offers In_Bus/Sel.
- In_Ready  output  1  block can accept this cycle.
- Out  output  WIDTH  selected word.
- Out_Sel  output  SEL_W  Sel value that produced Out.
- Sel_Err  output  1  Out came from an out-of-range Sel (Sel >= N_IN).
- Out_Valid  output  1  Out/Out_Sel/Sel_Err valid.
- Out_Ready  input  1  downstream accepts.
- Err_Count  output  8  out-of-range select counter (see Optional Feature).

Behaviour:
- Accept when In_Valid && In_Ready. Emit when Out_Valid && Out_Ready.
- Data path: word = (Sel < N_IN) ? In_Bus word Sel : 0; err = (Sel >= N_IN). The word, Sel and err travel together as one entry.
- Storage is two registers: the output register (drives Out/Out_Sel/Sel_Err, flag Out_Valid) and the skid register (flag skid_v).
- In_Ready = !skid_v. It is a registered flag only, with no combinational path from Out_Ready.
- Latency: an accepted entry appears on Out the next cycle if the output register is free or drains that cycle. Otherwise it lands in skid and appears one cycle after the output drains.
- Per cycle, with out_free = !Out_Valid || Out_Ready:
  - skid_v=1 and out_free: skid moves to output; skid_v<=0. No accept is possible (In_Ready=0).
  - skid_v=0, accept, out_free: entry goes to output; Out_Valid<=1.
  - skid_v=0, accept, !out_free: entry goes to skid; skid_v<=1. Output holds.
  - skid_v=0, no accept, out_free: Out_Valid<=0 if draining.
  - Otherwise hold.
- Ordering is strictly FIFO, at most 2 entries in flight.
- While Out_Valid=1 and Out_Ready=0, Out/Out_Sel/Sel_Err hold stable.
- Reset (Rst_n low, any time, including mid-transfer): Out_Valid=0, skid_v=0, Out=0, Out_Sel=0, Sel_Err=0, Err_Count=0, In_Ready=1. In-flight entries are discarded.
- Full throughput: with Out_Ready held high, one entry per cycle, no bubbles.
- In_Bus/Sel are don't-care when In_Valid=0. No X propagates into stored state on non-accept cycles.

Optional Feature:
- Macro: MUX_PIPE_ERR_COUNT_EN.
- Defined: Err_Count increments by 1 on each accepted entry with Sel >= N_IN. It saturates at 255 and resets only via Rst_n.
- Undefined: Err_Count tied to 0 and the counter logic is absent. Sel_Err is unaffected either way.

Test Plan:
- Reset then single transfer:
  - Stimulus: WIDTH=32, N_IN=8; word k = 32'h1000_0000+k; Sel=5, In_Valid one cycle, Out_Ready=1.
  - Response: next cycle Out=32'h1000_0005, Out_Sel=5, Sel_Err=0, Out_Valid=1 for one cycle.
- Back-to-back streaming:
  - Stimulus: Sel=0..7 on 8 consecutive cycles, Out_Ready=1.
  - Response: Out=32'h1000_0000..32'h1000_0007 on 8 consecutive cycles, In_Ready never drops.
- Backpressure / skid:
  - Stimulus: Out_Ready=0, send Sel=2 then Sel=3.
  - Response: Out holds 32'h1000_0002; In_Ready drops to 0 after the second accept; a third offer (Sel=4) is not accepted.
  - Then raise Out_Ready: outputs 2, 3, then 4 in order, no loss or duplication.
- Out-of-range select:
  - Stimulus: N_IN=6, SEL_W=3, Sel=7.
  - Response: Out=0, Sel_Err=1, Out_Sel=7. With MUX_PIPE_ERR_COUNT_EN, Err_Count=1; after 300 such selects, Err_Count=255.
- Reset mid-operation:
  - Stimulus: both registers full, assert Rst_n=0 asynchronously between edges.
  - Response: immediately Out_Valid=0, Out=0, In_Ready=1, Err_Count=0. After release, the first new accept appears with latency 1.
- Parameter sweep:
  - Stimulus: WIDTH=1/N_IN=2/SEL_W=1 and WIDTH=64/N_IN=64/SEL_W=6, random Sel/Valid/Ready for 10k cycles.
  - Response: output stream matches a reference queue model exactly.
